// File: rtl/obs_pkg.sv
// obs_pkg: shared types for the copy1/copy2 observation trace checker.
//   obs_kind_t  : kind of observation event (commit, load, store)
//   obs_t       : one buffered observation {kind, addr}
//   chk_state_e : checker control state
//   obs_differs : true when two observations do not match
package obs_pkg;

   // Widest address an observation can carry.
   // obs_trace_checker zero-extends narrower addresses into this field.
   localparam int OBS_AW = 32;

   typedef enum logic [1:0] {
      OBS_COMMIT = 2'd0,
      OBS_LOAD   = 2'd1,
      OBS_STORE  = 2'd2,
      OBS_RSVD   = 2'd3
   } obs_kind_t;

   typedef struct packed {
      obs_kind_t         kind;
      logic [OBS_AW-1:0] addr;
   } obs_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } chk_state_e;

   function automatic logic obs_differs(input obs_t x, input obs_t y);
      return (x.kind != y.kind) || (x.addr != y.addr);
   endfunction

endpackage

// File: rtl/obs_fifo.sv
// obs_fifo: DEPTH-entry FIFO of obs_t, one per observation stream.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_data at the tail (accepted if not full, or if popped this cycle)
//   push_data  entry to write
//   pop        remove the head (ignored when empty)
//   head       current head entry (valid when !empty)
//   full       DEPTH entries held
//   empty      no entries held
//   drop       push arrived while full and not popped: entry discarded this cycle
// Occupancy uses read/write pointers with one extra wrap bit, so all DEPTH+1
// fill levels are distinguishable. A push into an empty FIFO becomes visible
// at head only after the clock edge (no bypass path).
module obs_fifo
   import obs_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  obs_t push_data,
   input  logic pop,
   output obs_t head,
   output logic full,
   output logic empty,
   output logic drop
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   obs_t          mem [DEPTH];
   logic          do_pop;
   logic          do_push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

   // Pop frees its slot before the push lands, so a full FIFO that is
   // popped in the same cycle still accepts the new entry.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;

   assign head = mem[rd_ptr[IW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IW-1:0]] <= push_data;
   end

endmodule

// File: rtl/obs_trace_checker.sv
// obs_trace_checker: pairs the copy1 (a_*) and copy2 (b_*) observation
// streams in order and compares them event by event. The copies may drift
// by a bounded number of cycles.
// Ports:
//   clk, rst              clock, synchronous active-high reset (discards everything)
//   a_valid/a_kind/a_addr copy1 observation (kind: 0 COMMIT, 1 LOAD, 2 STORE)
//   b_valid/b_kind/b_addr copy2 observation
//   drain                 end of run: stop accepting, flush queued pairs, finish
//   mismatch              sticky: a pair differed, or stream lengths differed at the end
//   mismatch_idx          0-based pair index of the first mismatch
//   overflow              sticky: an observation was dropped on a full FIFO
//   skew_err              sticky: one stream led alone for MAX_SKEW cycles
//   done                  checker has finished (DONE state)
//   ok                    done with no sticky error
//   dbg_state             current control state (chk_state_e encoding)
// Stream handshake: x_valid is a one-cycle strobe with no backpressure.
// Every strobe in RUN is either queued or, when the FIFO is full and not
// being popped, dropped and flagged through overflow.
module obs_trace_checker
   import obs_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int AW       = 32,   // must not exceed OBS_AW
   parameter int MAX_SKEW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   input  logic [1:0]    a_kind,
   input  logic [AW-1:0] a_addr,
   input  logic          b_valid,
   input  logic [1:0]    b_kind,
   input  logic [AW-1:0] b_addr,
   input  logic          drain,
   output logic          mismatch,
   output logic [15:0]   mismatch_idx,
   output logic          overflow,
   output logic          skew_err,
   output logic          done,
   output logic          ok,
   output logic [1:0]    dbg_state
);

   localparam int SW = $clog2(MAX_SKEW + 1);
   localparam logic [SW-1:0] SKEW_LAST = SW'(MAX_SKEW - 1);

   chk_state_e  state;
   chk_state_e  state_nxt;

   obs_t        a_in, b_in;
   obs_t        a_head, b_head;
   logic        a_full, a_empty, a_drop;
   logic        b_full, b_empty, b_drop;
   logic        a_push, b_push;
   logic        pop_pair;
   logic        end_short;

   logic        cmp_v;
   obs_t        cmp_a, cmp_b;
   logic [15:0] cmp_idx;
   logic [15:0] pair_cnt;
   logic [SW-1:0] skew_cnt;

   always_comb begin
      a_in      = '0;
      a_in.kind = obs_kind_t'(a_kind);
      a_in.addr = OBS_AW'(a_addr);
      b_in      = '0;
      b_in.kind = obs_kind_t'(b_kind);
      b_in.addr = OBS_AW'(b_addr);
   end

   // Only RUN accepts observations; DRAIN and DONE ignore them, so no
   // overflow can be raised after drain.
   assign a_push   = a_valid & (state == ST_RUN);
   assign b_push   = b_valid & (state == ST_RUN);
   assign pop_pair = ~a_empty & ~b_empty & (state != ST_DONE);

   // Leaving DRAIN while one stream still holds entries means the copies
   // produced different numbers of events.
   assign end_short = (state == ST_DRAIN) && (state_nxt == ST_DONE) &&
                      !(a_empty && b_empty);

   obs_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (a_push),
      .push_data (a_in),
      .pop       (pop_pair),
      .head      (a_head),
      .full      (a_full),
      .empty     (a_empty),
      .drop      (a_drop)
   );

   obs_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (b_push),
      .push_data (b_in),
      .pop       (pop_pair),
      .head      (b_head),
      .full      (b_full),
      .empty     (b_empty),
      .drop      (b_drop)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Next-state logic. DONE needs the in-flight compare to retire first so
   // that a last-pair mismatch is reported with its own index.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (drain) state_nxt = ST_DRAIN;
         ST_DRAIN: if ((a_empty || b_empty) && !cmp_v) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // Output logic
   always_comb begin
      done      = (state == ST_DONE);
      ok        = done & ~mismatch & ~overflow & ~skew_err;
      dbg_state = state;
   end

   // Pairing, comparison and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_v        <= 1'b0;
         cmp_a        <= '0;
         cmp_b        <= '0;
         cmp_idx      <= '0;
         pair_cnt     <= '0;
         mismatch     <= 1'b0;
         mismatch_idx <= '0;
         overflow     <= 1'b0;
         skew_err     <= 1'b0;
         skew_cnt     <= '0;
      end else begin
         cmp_v <= pop_pair;
         if (pop_pair) begin
            cmp_a   <= a_head;
            cmp_b   <= b_head;
            cmp_idx <= pair_cnt;
            if (pair_cnt != 16'hFFFF) pair_cnt <= pair_cnt + 16'd1;
         end

         // First mismatch wins; its index is never overwritten.
         if (!mismatch) begin
            if (cmp_v && obs_differs(cmp_a, cmp_b)) begin
               mismatch     <= 1'b1;
               mismatch_idx <= cmp_idx;
            end else if (end_short) begin
               mismatch     <= 1'b1;
               mismatch_idx <= pair_cnt;
            end
         end

         if (a_drop || b_drop) overflow <= 1'b1;

         // Count consecutive cycles in which exactly one stream has
         // entries waiting; the counter holds once the limit is hit.
         if (a_empty != b_empty) begin
            if (skew_cnt == SKEW_LAST) skew_err <= 1'b1;
            else                       skew_cnt <= skew_cnt + 1'b1;
         end else begin
            skew_cnt <= '0;
         end
      end
   end

endmodule
